// File: rtl/fpadd_pkg.sv
// Shared constants, state codes and binary32 field helpers
// for the sequential FP adder.
package fpadd_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 1;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  localparam logic [EXP_W-1:0] EXP_ALL1 = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_TOP  = 8'hFE;
  localparam logic [EXP_W-1:0] EXP_ONE  = 8'h01;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic [31:0] fp_pack(
    input logic             s,
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] f
  );
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 operand classifier; denormals read as zero
// so the datapath never sees a sig without its hidden bit.
module fp_classify
  import fpadd_pkg::*;
(
  input  logic [31:0]      x_i,
  output logic             sign_o,
  output logic             is_zero_o,
  output logic             is_inf_o,
  output logic             is_nan_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [SIG_W-1:0] sig_o
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;

  assign e = fp_exp(x_i);
  assign f = fp_frac(x_i);

  assign sign_o    = fp_sign(x_i);
  assign is_zero_o = (e == '0);
  assign is_inf_o  = (e == EXP_ALL1) && (f == '0);
  assign is_nan_o  = (e == EXP_ALL1) && (f != '0);
  assign exp_o     = e;
  assign sig_o     = is_zero_o ? '0 : {1'b1, f};

endmodule

// File: rtl/fpadd_seq_ctrl.sv
// Multi-cycle binary32 adder: one op in flight, stepping a shared
// datapath through align, add, normalise and pack.
module fpadd_seq_ctrl
  import fpadd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum_out,
  output logic        busy
);

  logic [2:0]       state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0] siga_q, siga_d;
  logic [SIG_W-1:0] sigb_q, sigb_d;
  logic [SIG_W:0]   sig_q, sig_d;
  logic [31:0]      res_q, res_d;

  logic             ca_sign, ca_zero, ca_inf, ca_nan;
  logic             cb_sign, cb_zero, cb_inf, cb_nan;
  logic [EXP_W-1:0] ca_exp, cb_exp;
  logic [SIG_W-1:0] ca_sig, cb_sig;

  fp_classify u_cls_a (
    .x_i      (a_q),
    .sign_o   (ca_sign),
    .is_zero_o(ca_zero),
    .is_inf_o (ca_inf),
    .is_nan_o (ca_nan),
    .exp_o    (ca_exp),
    .sig_o    (ca_sig)
  );

  fp_classify u_cls_b (
    .x_i      (b_q),
    .sign_o   (cb_sign),
    .is_zero_o(cb_zero),
    .is_inf_o (cb_inf),
    .is_nan_o (cb_nan),
    .exp_o    (cb_exp),
    .sig_o    (cb_sig)
  );

  logic             a_ge_b;
  logic [EXP_W-1:0] big_exp, sml_exp, shamt;
  logic [SIG_W-1:0] big_sig, sml_sig, sml_sh;
  logic [SIG_W:0]   sum, sig_r, sig_l;
  logic [EXP_W-1:0] exp_inc, exp_dec;

  assign a_ge_b  = {ca_exp, ca_sig} >= {cb_exp, cb_sig};
  assign big_exp = a_ge_b ? ca_exp : cb_exp;
  assign sml_exp = a_ge_b ? cb_exp : ca_exp;
  assign big_sig = a_ge_b ? ca_sig : cb_sig;
  assign sml_sig = a_ge_b ? cb_sig : ca_sig;
  assign shamt   = big_exp - sml_exp;
  // Truncating align: anything shifted past the sig width is lost
  assign sml_sh  = (shamt >= 8'd24) ? '0 : (sml_sig >> shamt);

  assign sum     = sub_q ? ({1'b0, siga_q} - {1'b0, sigb_q})
                         : ({1'b0, siga_q} + {1'b0, sigb_q});
  assign sig_r   = sig_q >> 1;
  assign sig_l   = sig_q << 1;
  assign exp_inc = exp_q + 8'd1;
  assign exp_dec = exp_q - 8'd1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    siga_d  = siga_q;
    sigb_d  = sigb_q;
    sig_d   = sig_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_d = S_DONE;
        if (ca_nan || cb_nan || (ca_inf && cb_inf && (ca_sign != cb_sign))) begin
          res_d = QNAN;
        end else if (ca_inf) begin
          res_d = ca_sign ? NEG_INF : POS_INF;
        end else if (cb_inf) begin
          res_d = cb_sign ? NEG_INF : POS_INF;
        end else if (ca_zero && cb_zero) begin
          res_d = {ca_sign & cb_sign, 31'b0};
        end else begin
          sign_d  = a_ge_b ? ca_sign : cb_sign;
          sub_d   = ca_sign ^ cb_sign;
          exp_d   = big_exp;
          siga_d  = big_sig;
          sigb_d  = sml_sh;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sig_d = sum;
        if (sum == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else if (!sum[SIG_W] && sum[SIG_W-1]) begin
          res_d   = fp_pack(sign_q, exp_q, sum[MAN_W-1:0]);
          state_d = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        // Each cycle shifts once and packs if that shift normalised
        if (sig_q[SIG_W]) begin
          state_d = S_DONE;
          if (exp_q == EXP_TOP) begin
            res_d = sign_q ? NEG_INF : POS_INF;
          end else begin
            sig_d = sig_r;
            exp_d = exp_inc;
            res_d = fp_pack(sign_q, exp_inc, sig_r[MAN_W-1:0]);
          end
        end else if (!sig_q[SIG_W-1]) begin
          if (exp_q == EXP_ONE) begin
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            sig_d = sig_l;
            exp_d = exp_dec;
            if (sig_q[SIG_W-2]) begin
              res_d   = fp_pack(sign_q, exp_dec, sig_l[MAN_W-1:0]);
              state_d = S_DONE;
            end
          end
        end else begin
          res_d   = fp_pack(sign_q, exp_q, sig_q[MAN_W-1:0]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      siga_q  <= '0;
      sigb_q  <= '0;
      sig_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      siga_q  <= siga_d;
      sigb_q  <= sigb_d;
      sig_q   <= sig_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum_out   = res_q;

endmodule
